pulse_filter_array: RTL

- Parametrised N-channel glitch filter, successor to the fixed 32-channel/22-bit filter top.
- Each channel has:
  - an input synchroniser and a stability counter with a shared coefficient
  - a per-channel enable
  - edge-event detection and sticky event flags with write-1-clear
  - a masked, registered interrupt
- Sits between raw pulse/switch inputs and the control/register logic.

---
 rtl/pulse_filter_array_if.sv | 49 ++++
 rtl/pulse_filter_array.sv | 132 +++++++++++++
 2 files changed

// File: rtl/pulse_filter_array_if.sv
// Signal bundle between the raw-input/register side and the pulse filter array.
// The master drives inputs and control, the slave (the filter) drives status and events.
interface pulse_filter_array_if #(
   parameter int CH_NUM    = 32,
   parameter int CNT_W     = 22,
   parameter int EVT_CNT_W = 8
) ();

   logic [CH_NUM-1:0]           pulse_in;
   logic [CNT_W-1:0]            filter_coeff;
   logic [CH_NUM-1:0]           ch_en;
   logic [CH_NUM-1:0]           irq_mask;
   logic [CH_NUM-1:0]           evt_clr;
   logic [CH_NUM-1:0]           pulse_out;
   logic [CH_NUM-1:0]           rise_evt;
   logic [CH_NUM-1:0]           fall_evt;
   logic [CH_NUM-1:0]           evt_sticky;
   logic                        irq;
   logic [CH_NUM*EVT_CNT_W-1:0] evt_cnt;

   modport master (
      output pulse_in,
      output filter_coeff,
      output ch_en,
      output irq_mask,
      output evt_clr,
      input  pulse_out,
      input  rise_evt,
      input  fall_evt,
      input  evt_sticky,
      input  irq,
      input  evt_cnt
   );

   modport slave (
      input  pulse_in,
      input  filter_coeff,
      input  ch_en,
      input  irq_mask,
      input  evt_clr,
      output pulse_out,
      output rise_evt,
      output fall_evt,
      output evt_sticky,
      output irq,
      output evt_cnt
   );

endinterface

// File: rtl/pulse_filter_array.sv
// N-channel glitch filter: synchroniser, stability counter, edge events, sticky flags, masked irq.
// Define PULSE_FILTER_EVT_CNT_EN to build the per-channel saturating rise counters.
module pulse_filter_array #(
   parameter int CH_NUM      = 32,
   parameter int CNT_W       = 22,
   parameter int SYNC_STAGES = 2,
   parameter int EVT_CNT_W   = 8
) (
   input logic                 clk,
   input logic                 rst_n,
   pulse_filter_array_if.slave io_bus
);

   logic [CH_NUM-1:0] r_sync [SYNC_STAGES];
   logic [CNT_W-1:0]  r_cnt  [CH_NUM];
   logic [CH_NUM-1:0] r_pulse;
   logic [CH_NUM-1:0] r_rise;
   logic [CH_NUM-1:0] r_fall;
   logic [CH_NUM-1:0] r_sticky;
   logic              r_irq;

   logic [CH_NUM-1:0] w_syncIn;
   logic [CNT_W-1:0]  w_cntNext [CH_NUM];
   logic [CH_NUM-1:0] w_accept;
   logic [CH_NUM-1:0] w_riseNext;
   logic [CH_NUM-1:0] w_fallNext;

   // Plain shift chain per channel; keeps running even for disabled channels.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int s = 0; s < SYNC_STAGES; s++) begin
            r_sync[s] <= '0;
         end
      end else begin
         r_sync[0] <= io_bus.pulse_in;
         for (int s = 1; s < SYNC_STAGES; s++) begin
            r_sync[s] <= r_sync[s-1];
         end
      end
   end

   assign w_syncIn = r_sync[SYNC_STAGES-1];

   // The counter only advances while sync_in disagrees with pulse_out, so it never exceeds the coefficient.
   always_comb begin
      w_accept = '0;
      for (int i = 0; i < CH_NUM; i++) begin
         w_cntNext[i] = '0;
         if (io_bus.ch_en[i] && (w_syncIn[i] != r_pulse[i])) begin
            if (r_cnt[i] >= io_bus.filter_coeff) begin
               w_accept[i] = 1'b1;
            end else begin
               w_cntNext[i] = r_cnt[i] + 1'b1;
            end
         end
      end
   end

   assign w_riseNext = w_accept & w_syncIn;
   assign w_fallNext = w_accept & ~w_syncIn;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < CH_NUM; i++) begin
            r_cnt[i] <= '0;
         end
         r_pulse  <= '0;
         r_rise   <= '0;
         r_fall   <= '0;
         r_sticky <= '0;
         r_irq    <= 1'b0;
      end else begin
         for (int i = 0; i < CH_NUM; i++) begin
            r_cnt[i] <= w_cntNext[i];
         end
         r_pulse  <= (r_pulse & ~w_accept) | (w_syncIn & w_accept);
         r_rise   <= w_riseNext;
         r_fall   <= w_fallNext;
         // A new edge beats a simultaneous clear so no event is ever lost.
         r_sticky <= (r_sticky & ~io_bus.evt_clr) | w_accept;
         r_irq    <= |(r_sticky & io_bus.irq_mask);
      end
   end

   assign io_bus.pulse_out  = r_pulse;
   assign io_bus.rise_evt   = r_rise;
   assign io_bus.fall_evt   = r_fall;
   assign io_bus.evt_sticky = r_sticky;
   assign io_bus.irq        = r_irq;

`ifdef PULSE_FILTER_EVT_CNT_EN
   logic [EVT_CNT_W-1:0]        r_evtCnt [CH_NUM];
   logic [EVT_CNT_W-1:0]        w_evtCntNext [CH_NUM];
   logic [CH_NUM*EVT_CNT_W-1:0] w_evtCntFlat;

   // Clear restarts the count, but a rise in the clear cycle is still counted.
   always_comb begin
      for (int i = 0; i < CH_NUM; i++) begin
         w_evtCntNext[i] = r_evtCnt[i];
         if (io_bus.evt_clr[i]) begin
            w_evtCntNext[i] = {{(EVT_CNT_W-1){1'b0}}, w_riseNext[i]};
         end else if (w_riseNext[i] && !(&r_evtCnt[i])) begin
            w_evtCntNext[i] = r_evtCnt[i] + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < CH_NUM; i++) begin
            r_evtCnt[i] <= '0;
         end
      end else begin
         for (int i = 0; i < CH_NUM; i++) begin
            r_evtCnt[i] <= w_evtCntNext[i];
         end
      end
   end

   always_comb begin
      w_evtCntFlat = '0;
      for (int i = 0; i < CH_NUM; i++) begin
         w_evtCntFlat[i*EVT_CNT_W +: EVT_CNT_W] = r_evtCnt[i];
      end
   end

   assign io_bus.evt_cnt = w_evtCntFlat;
`else
   assign io_bus.evt_cnt = '0;
`endif

endmodule
